// File: rtl/pulse_blinker.sv
// pulse_blinker: turns single-cycle event pulses into queued, human-visible LED flashes.
// Each flash is ON_TICKS ticks lit followed by OFF_TICKS ticks dark.
module pulse_blinker #(
    parameter int DIV_BITS  = 21,
    parameter int ON_TICKS  = 4,
    parameter int OFF_TICKS = 2,
    parameter int CNT_BITS  = 4
) (
    input  logic                sysclk,
    input  logic                reset,
    input  logic                pulse_in,
    output logic                led,
    output logic                busy,
    output logic [CNT_BITS-1:0] pending,
    output logic                overflow
);
    typedef enum logic [1:0] {IDLE, ON, GAP} state_t;
    state_t              state_q, state_d;
    logic [DIV_BITS-1:0] presc_q, presc_d;
    logic [7:0]          tcnt_q, tcnt_d;
    logic [CNT_BITS-1:0] pend_q, pend_d;
    logic                ovf_q, ovf_d, led_q, led_d;
    logic                tick, moved, to_on, sat;

    always_ff @(posedge sysclk) begin
        if (reset) begin
            state_q <= IDLE;
            presc_q <= '0;
            tcnt_q  <= '0;
            pend_q  <= '0;
            ovf_q   <= 1'b0;
            led_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            tcnt_q  <= tcnt_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
            led_q   <= led_d;
        end
    end

    always_comb begin
        tick    = &presc_q;
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = (pend_q != '0) ? ON : IDLE;
            ON:      state_d = (tick && tcnt_q == 8'(ON_TICKS - 1)) ? GAP : ON;
            GAP:     state_d = (tick && tcnt_q == 8'(OFF_TICKS - 1)) ? ((pend_q != '0) ? ON : IDLE) : GAP;
            default: state_d = IDLE;
        endcase
    end

    // Every state change restarts both timers so each interval is phase-aligned.
    always_comb begin
        moved   = state_d != state_q;
        to_on   = moved && state_d == ON;
        sat     = &pend_q;
        presc_d = moved ? '0 : presc_q + 1'b1;
        tcnt_d  = (moved || state_q == IDLE) ? '0 : tcnt_q + 8'(tick);
        pend_d  = (pulse_in && !to_on && !sat) ? pend_q + 1'b1 :
                  (!pulse_in && to_on)         ? pend_q - 1'b1 : pend_q;
        ovf_d   = ovf_q | (pulse_in & ~to_on & sat);
        led_d   = state_d == ON;
    end

    always_comb begin
        led      = led_q;
        busy     = state_q != IDLE;
        pending  = pend_q;
        overflow = ovf_q;
    end
endmodule

// File: tb/tb_pulse_blinker.sv
// tb_pulse_blinker: run-length vector table for the small configuration plus a
// longer-prescaler sequence checking exact on/off durations.
module tb_pulse_blinker;
    logic       sysclk = 1'b0;
    logic       reset = 1'b1, pulse_in = 1'b0;
    logic       led, busy, overflow;
    logic [1:0] pending;
    logic       r2 = 1'b1, p2 = 1'b0;
    logic       led2, busy2, ovf2;
    logic [3:0] pend2;
    int         checks = 0, errors = 0;

    typedef struct {
        int         len;
        logic       rst;
        logic       pls;
        logic       led;
        logic       busy;
        logic [1:0] pend;
        logic       ovf;
    } vec_t;
    vec_t vecs[$];

    always #5 sysclk = ~sysclk;

    pulse_blinker #(.DIV_BITS(2), .ON_TICKS(3), .OFF_TICKS(2), .CNT_BITS(2)) dut (
        .sysclk(sysclk), .reset(reset), .pulse_in(pulse_in),
        .led(led), .busy(busy), .pending(pending), .overflow(overflow)
    );

    pulse_blinker #(.DIV_BITS(8), .ON_TICKS(4), .OFF_TICKS(2), .CNT_BITS(4)) dut_big (
        .sysclk(sysclk), .reset(r2), .pulse_in(p2),
        .led(led2), .busy(busy2), .pending(pend2), .overflow(ovf2)
    );

    task automatic add(input int len, input logic rst, input logic pls, input logic l,
                       input logic b, input logic [1:0] pn, input logic o);
        vecs.push_back('{len, rst, pls, l, b, pn, o});
    endtask

    task automatic step;
        @(posedge sysclk);
        #1;
    endtask

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, got, want);
        end
    endtask

    initial begin
        int n;
        // single pulse
        add(1, 1, 0, 0, 0, 0, 0);
        add(10, 0, 0, 0, 0, 0, 0);
        add(1, 0, 1, 0, 0, 1, 0);
        add(12, 0, 0, 1, 1, 0, 0);
        add(8, 0, 0, 0, 1, 0, 0);
        add(4, 0, 0, 0, 0, 0, 0);
        // queued pulses at 10, 15, 20
        add(1, 1, 0, 0, 0, 0, 0);
        add(10, 0, 0, 0, 0, 0, 0);
        add(1, 0, 1, 0, 0, 1, 0);
        add(4, 0, 0, 1, 1, 0, 0);
        add(1, 0, 1, 1, 1, 1, 0);
        add(4, 0, 0, 1, 1, 1, 0);
        add(1, 0, 1, 1, 1, 2, 0);
        add(2, 0, 0, 1, 1, 2, 0);
        add(8, 0, 0, 0, 1, 2, 0);
        add(12, 0, 0, 1, 1, 1, 0);
        add(8, 0, 0, 0, 1, 1, 0);
        add(12, 0, 0, 1, 1, 0, 0);
        add(8, 0, 0, 0, 1, 0, 0);
        add(4, 0, 0, 0, 0, 0, 0);
        // saturation: five pulses during ON
        add(1, 1, 0, 0, 0, 0, 0);
        add(10, 0, 0, 0, 0, 0, 0);
        add(1, 0, 1, 0, 0, 1, 0);
        add(3, 0, 0, 1, 1, 0, 0);
        add(1, 0, 1, 1, 1, 1, 0);
        add(1, 0, 1, 1, 1, 2, 0);
        add(1, 0, 1, 1, 1, 3, 0);
        add(2, 0, 1, 1, 1, 3, 1);
        add(4, 0, 0, 1, 1, 3, 1);
        add(8, 0, 0, 0, 1, 3, 1);
        add(12, 0, 0, 1, 1, 2, 1);
        add(8, 0, 0, 0, 1, 2, 1);
        add(12, 0, 0, 1, 1, 1, 1);
        add(8, 0, 0, 0, 1, 1, 1);
        add(12, 0, 0, 1, 1, 0, 1);
        add(8, 0, 0, 0, 1, 0, 1);
        add(6, 0, 0, 0, 0, 0, 1);
        // simultaneous inc/dec on the last GAP cycle
        add(1, 1, 0, 0, 0, 0, 0);
        add(10, 0, 0, 0, 0, 0, 0);
        add(1, 0, 1, 0, 0, 1, 0);
        add(9, 0, 0, 1, 1, 0, 0);
        add(1, 0, 1, 1, 1, 1, 0);
        add(2, 0, 0, 1, 1, 1, 0);
        add(8, 0, 0, 0, 1, 1, 0);
        add(1, 0, 1, 1, 1, 1, 0);
        add(11, 0, 0, 1, 1, 1, 0);
        add(8, 0, 0, 0, 1, 1, 0);
        add(12, 0, 0, 1, 1, 0, 0);
        add(8, 0, 0, 0, 1, 0, 0);
        add(4, 0, 0, 0, 0, 0, 0);
        // reset on the 5th ON cycle with two flashes queued; concurrent pulse ignored
        add(1, 1, 0, 0, 0, 0, 0);
        add(10, 0, 0, 0, 0, 0, 0);
        add(1, 0, 1, 0, 0, 1, 0);
        add(1, 0, 0, 1, 1, 0, 0);
        add(1, 0, 1, 1, 1, 1, 0);
        add(1, 0, 1, 1, 1, 2, 0);
        add(2, 0, 0, 1, 1, 2, 0);
        add(1, 1, 1, 0, 0, 0, 0);
        add(30, 0, 0, 0, 0, 0, 0);

        foreach (vecs[i]) begin
            for (int k = 0; k < vecs[i].len; k++) begin
                reset    = vecs[i].rst;
                pulse_in = vecs[i].pls;
                step();
                checks++;
                if ({led, busy, pending, overflow} !== {vecs[i].led, vecs[i].busy, vecs[i].pend, vecs[i].ovf}) begin
                    errors++;
                    $display("FAIL vec%0d step%0d got led=%b busy=%b pending=%0d overflow=%b want led=%b busy=%b pending=%0d overflow=%b",
                             i, k, led, busy, pending, overflow,
                             vecs[i].led, vecs[i].busy, vecs[i].pend, vecs[i].ovf);
                end
            end
        end

        // longer prescaler: ON = 4*256 cycles, GAP = 2*256 cycles
        reset = 1'b1;
        r2    = 1'b1;
        step();
        r2 = 1'b0;
        chk("big_reset_led", int'(led2), 0);
        chk("big_reset_busy", int'(busy2), 0);
        repeat (5) step();
        p2 = 1'b1;
        step();
        p2 = 1'b0;
        chk("big_pend_n1", int'(pend2), 1);
        chk("big_led_n1", int'(led2), 0);
        step();
        chk("big_led_n2", int'(led2), 1);
        chk("big_pend_n2", int'(pend2), 0);
        n = 0;
        while (led2 && n < 2000) begin
            n++;
            step();
        end
        chk("big_on_cycles", n, 1024);
        n = 0;
        while (busy2 && !led2 && n < 2000) begin
            n++;
            step();
        end
        chk("big_gap_cycles", n, 512);
        chk("big_idle_busy", int'(busy2), 0);
        chk("big_idle_led", int'(led2), 0);
        chk("big_ovf", int'(ovf2), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
